// File: rtl/id_ex_operand_stage.sv
// ID/EX operand stage: forwards, selects imm/subtract, and holds a 2-entry skid buffer in front of the EX adder.
// Latency 1 cycle from accept to A/B/Cin; in_ready is registered and drops only when both entries are held.
module id_ex_operand_stage #(
    parameter int XLEN   = 64,
    parameter int REGIDX = 5
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_rs1_val,
    input  logic [XLEN-1:0]   in_rs2_val,
    input  logic [XLEN-1:0]   in_imm,
    input  logic [REGIDX-1:0] in_rs1_idx,
    input  logic [REGIDX-1:0] in_rs2_idx,
    input  logic [REGIDX-1:0] in_rd_idx,
    input  logic              in_use_imm,
    input  logic              in_sub,
    input  logic              exm_wr,
    input  logic [REGIDX-1:0] exm_rd,
    input  logic [XLEN-1:0]   exm_data,
    input  logic              mwb_wr,
    input  logic [REGIDX-1:0] mwb_rd,
    input  logic [XLEN-1:0]   mwb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   A,
    output logic [XLEN-1:0]   B,
    output logic              Cin,
    output logic [REGIDX-1:0] out_rd_idx
);

    typedef struct packed {
        logic [XLEN-1:0]   a;
        logic [XLEN-1:0]   b;
        logic              cin;
        logic [REGIDX-1:0] rd;
    } entry_t;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} occ_t;

    occ_t            state;
    entry_t          main_q;
    entry_t          skid_q;
    entry_t          new_entry;
    logic [XLEN-1:0] rs1_res;
    logic [XLEN-1:0] rs2_res;
    logic [XLEN-1:0] b_raw;
    logic            accept;

    assign accept = in_valid & in_ready;

    // EX/MEM is younger than MEM/WB, so it takes priority; x0 is hardwired zero and never forwarded.
    always_comb begin
        rs1_res = in_rs1_val;
        if (in_rs1_idx != '0 && exm_wr && exm_rd == in_rs1_idx)
            rs1_res = exm_data;
        else if (in_rs1_idx != '0 && mwb_wr && mwb_rd == in_rs1_idx)
            rs1_res = mwb_data;

        rs2_res = in_rs2_val;
        if (in_rs2_idx != '0 && exm_wr && exm_rd == in_rs2_idx)
            rs2_res = exm_data;
        else if (in_rs2_idx != '0 && mwb_wr && mwb_rd == in_rs2_idx)
            rs2_res = mwb_data;

        b_raw         = in_use_imm ? in_imm : rs2_res;
        new_entry.a   = rs1_res;
        new_entry.b   = in_sub ? ~b_raw : b_raw;
        new_entry.cin = in_sub;
        new_entry.rd  = in_rd_idx;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state     <= EMPTY;
            main_q    <= '0;
            skid_q    <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else if (flush) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                EMPTY: if (accept) begin
                    main_q    <= new_entry;
                    state     <= ONE;
                    out_valid <= 1'b1;
                end
                ONE: begin
                    if (accept && out_ready) begin
                        main_q <= new_entry;
                    end else if (accept) begin
                        skid_q   <= new_entry;
                        state    <= FULL;
                        in_ready <= 1'b0;
                    end else if (out_ready) begin
                        state     <= EMPTY;
                        out_valid <= 1'b0;
                    end
                end
                FULL: if (out_ready) begin
                    main_q   <= skid_q;
                    state    <= ONE;
                    in_ready <= 1'b1;
                end
                default: begin
                    state     <= EMPTY;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign A          = main_q.a;
    assign B          = main_q.b;
    assign Cin        = main_q.cin;
    assign out_rd_idx = main_q.rd;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Scoreboard bench: the reference model is an ordered queue of expected adder operands holding at most two entries.
module tb_id_ex_operand_stage;

    logic        Clk = 1'b0;
    logic        Rst, flush, in_valid, in_ready;
    logic [63:0] in_rs1_val, in_rs2_val, in_imm;
    logic [4:0]  in_rs1_idx, in_rs2_idx, in_rd_idx;
    logic        in_use_imm, in_sub;
    logic        exm_wr, mwb_wr;
    logic [4:0]  exm_rd, mwb_rd;
    logic [63:0] exm_data, mwb_data;
    logic        out_valid, out_ready;
    logic [63:0] A, B;
    logic        Cin;
    logic [4:0]  out_rd_idx;

    id_ex_operand_stage dut (
        .Clk(Clk), .Rst(Rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .in_imm(in_imm),
        .in_rs1_idx(in_rs1_idx), .in_rs2_idx(in_rs2_idx), .in_rd_idx(in_rd_idx),
        .in_use_imm(in_use_imm), .in_sub(in_sub),
        .exm_wr(exm_wr), .exm_rd(exm_rd), .exm_data(exm_data),
        .mwb_wr(mwb_wr), .mwb_rd(mwb_rd), .mwb_data(mwb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .A(A), .B(B), .Cin(Cin), .out_rd_idx(out_rd_idx)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        logic [4:0]  rd;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passed = 0;
    bit   was_reset = 0;
    bit   sim_done = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act === expv) passed++;
        else $display("FAIL %s got=%h expected=%h t=%0t", nm, act, expv, $time);
    endtask

    // Source value seen by the adder: newest in-flight writer wins, register 0 reads the regfile.
    function automatic logic [63:0] operand(input logic [4:0] idx, input logic [63:0] rf);
        if (idx == 0) return rf;
        if (exm_wr && exm_rd == idx) return exm_data;
        if (mwb_wr && mwb_rd == idx) return mwb_data;
        return rf;
    endfunction

    // Monitor: inputs and outputs are both stable at the falling edge.
    always @(negedge Clk) begin
        if (!sim_done) begin
            if (was_reset) begin
                chk("rst_A", A, 64'd0);
                chk("rst_B", B, 64'd0);
                chk("rst_cin", 64'(Cin), 64'd0);
                chk("rst_rd", 64'(out_rd_idx), 64'd0);
            end
            chk("in_ready", 64'(in_ready), 64'(exp_q.size() < 2));
            chk("out_valid", 64'(out_valid), 64'(exp_q.size() > 0));
            if (exp_q.size() > 0 && out_ready) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("A", A, e.a);
                chk("B", B, e.b);
                chk("cin", 64'(Cin), 64'(e.cin));
                chk("rd", 64'(out_rd_idx), 64'(e.rd));
            end
            if (in_valid && (exp_q.size() + ((out_valid && out_ready) ? 1 : 0)) < 2) begin
                exp_t n;
                logic [63:0] braw;
                braw  = in_use_imm ? in_imm : operand(in_rs2_idx, in_rs2_val);
                n.a   = operand(in_rs1_idx, in_rs1_val);
                n.b   = in_sub ? (64'hFFFF_FFFF_FFFF_FFFF - braw) : braw;
                n.cin = in_sub;
                n.rd  = in_rd_idx;
                exp_q.push_back(n);
            end
            if (Rst || flush) exp_q.delete();
            was_reset = Rst;
        end
    end

    task automatic drive(input logic v, input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                         input logic [63:0] v1, input logic [63:0] v2, input logic [63:0] imm,
                         input logic ui, input logic sb, input logic ordy, input logic fl);
        in_valid = v; in_rs1_idx = r1; in_rs2_idx = r2; in_rd_idx = rd;
        in_rs1_val = v1; in_rs2_val = v2; in_imm = imm;
        in_use_imm = ui; in_sub = sb; out_ready = ordy; flush = fl;
        @(posedge Clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    endtask

    initial begin
        Rst = 1; exm_wr = 0; mwb_wr = 0; exm_rd = 0; mwb_rd = 0; exm_data = 0; mwb_data = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        Rst = 0;
        // Plain add, then subtract of the same operands.
        drive(1, 5, 7, 1, 64'd10, 64'd3, 64'd0, 0, 0, 1, 0);
        drive(1, 5, 7, 2, 64'd10, 64'd3, 64'd0, 0, 1, 1, 0);
        // Forwarding priority and x0 exclusion.
        exm_wr = 1; exm_rd = 4; exm_data = 64'hAA; mwb_wr = 1; mwb_rd = 4; mwb_data = 64'hBB;
        drive(1, 4, 4, 3, 64'h11, 64'h22, 64'h5, 1, 0, 1, 0);
        exm_wr = 0;
        drive(1, 4, 4, 3, 64'h11, 64'h22, 64'h5, 0, 0, 1, 0);
        exm_wr = 1; exm_rd = 0; mwb_rd = 0;
        drive(1, 0, 0, 6, 64'h11, 64'h22, 64'h5, 0, 1, 1, 0);
        exm_wr = 0; mwb_wr = 0;
        idle(2);
        // Back-pressure: three offered, two held, drain in order.
        for (int i = 0; i < 3; i++) drive(1, 1, 2, 5'(8 + i), 64'(100 + i), 64'(200 + i), 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        // Flush while full with a new instruction offered.
        for (int i = 0; i < 2; i++) drive(1, 1, 2, 5'(12 + i), 64'(300 + i), 64'(400 + i), 0, 0, 0, 0, 0);
        drive(1, 1, 2, 14, 64'd302, 64'd402, 0, 0, 0, 0, 1);
        idle(2);
        // Reset while full.
        for (int i = 0; i < 2; i++) drive(1, 1, 2, 5'(16 + i), 64'(500 + i), 64'(600 + i), 0, 1, 1, 0, 0);
        Rst = 1;
        drive(1, 3, 3, 20, 64'd7, 64'd8, 0, 0, 0, 0, 0);
        Rst = 0;
        idle(2);
        for (int c = 0; c < 3000; c++) begin
            Rst      = ($urandom_range(0, 199) == 0);
            exm_wr   = 1'($urandom);  exm_rd = 5'($urandom_range(0, 3));
            mwb_wr   = 1'($urandom);  mwb_rd = 5'($urandom_range(0, 3));
            exm_data = {$urandom, $urandom}; mwb_data = {$urandom, $urandom};
            drive(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  5'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                  1'($urandom), 1'($urandom), 1'($urandom_range(0, 2) != 0), ($urandom_range(0, 63) == 0));
        end
        Rst = 0; exm_wr = 0; mwb_wr = 0;
        idle(4);
        @(negedge Clk);
        #1;
        sim_done = 1;
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
